// File: rtl/tanh_stim_pkg.sv
// tanh_stim_pkg: shared FSM state type and fixed-point defaults for the tanh stimulus blocks.
package tanh_stim_pkg;
  typedef enum logic [1:0] {IDLE, EMIT, HOLD, DONE} state_e;
  localparam int DEF_WIDTH    = 18;
  localparam int DEF_EXPONENT = -12;
  localparam logic signed [DEF_WIDTH-1:0] FX_MAX = {1'b0, {(DEF_WIDTH-1){1'b1}}};
  localparam logic signed [DEF_WIDTH-1:0] FX_MIN = {1'b1, {(DEF_WIDTH-1){1'b0}}};
endpackage

// File: rtl/fixed_sat_add.sv
// fixed_sat_add: combinational signed saturating adder.
//   a, b : WIDTH-bit signed operands
//   sum  : a+b clamped to the signed WIDTH-bit range
//   ovf  : high when the clamp was applied
module fixed_sat_add
  import tanh_stim_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] sum,
  output logic                    ovf
);
  logic signed [WIDTH:0] wide;
  always_comb begin
    wide = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    ovf  = wide[WIDTH] ^ wide[WIDTH-1];
    // On overflow the true sign is the extra bit: clamp to MAX or MIN accordingly.
    sum  = ovf ? {wide[WIDTH], {(WIDTH-1){~wide[WIDTH]}}} : wide[WIDTH-1:0];
  end
endmodule

// File: rtl/tanh_stim_sweep.sv
// tanh_stim_sweep: saturating fixed-point ramp generator with valid/ready output and hold gaps.
//   start + start_val/step/n_steps/hold_cycles : sweep request and its configuration
//   out_val/out_valid/out_ready                : sample handshake toward the model input
//   busy (EMIT/HOLD), done (level), sat (sticky clip flag)
module tanh_stim_sweep
  import tanh_stim_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int EXPONENT = DEF_EXPONENT,
  parameter int CNT_W    = 16,
  parameter int HOLD_W   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] start_val,
  input  logic signed [WIDTH-1:0] step,
  input  logic [CNT_W-1:0]        n_steps,
  input  logic [HOLD_W-1:0]       hold_cycles,
  output logic signed [WIDTH-1:0] out_val,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    done,
  output logic                    sat
);
  state_e                  state_q, state_d;
  logic signed [WIDTH-1:0] out_val_q, out_val_d;
  logic signed [WIDTH-1:0] step_q, step_d;
  logic [CNT_W-1:0]        n_q, n_d, idx_q, idx_d;
  logic [HOLD_W-1:0]       hold_q, hold_d, hcnt_q, hcnt_d;
  logic                    sat_q, sat_d;
  logic signed [WIDTH-1:0] next_val;
  logic                    next_ovf;

  fixed_sat_add #(.WIDTH(WIDTH)) u_add (
    .a   (out_val_q),
    .b   (step_q),
    .sum (next_val),
    .ovf (next_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      out_val_q <= '0;
      step_q    <= '0;
      n_q       <= '0;
      idx_q     <= '0;
      hold_q    <= '0;
      hcnt_q    <= '0;
      sat_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_val_q <= out_val_d;
      step_q    <= step_d;
      n_q       <= n_d;
      idx_q     <= idx_d;
      hold_q    <= hold_d;
      hcnt_q    <= hcnt_d;
      sat_q     <= sat_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    out_val_d = out_val_q;
    step_d    = step_q;
    n_d       = n_q;
    idx_d     = idx_q;
    hold_d    = hold_q;
    hcnt_d    = hcnt_q;
    sat_d     = sat_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          step_d  = step;
          n_d     = n_steps;
          hold_d  = hold_cycles;
          sat_d   = 1'b0;
          state_d = (n_steps == '0) ? DONE : EMIT;
          if (n_steps != '0) begin
            out_val_d = start_val;
            idx_d     = '0;
          end
        end
      end
      EMIT: begin
        // The adder result is only committed on an accept, so a stalled sample stays put.
        if (out_ready) begin
          if (idx_q == n_q - CNT_W'(1)) begin
            state_d = DONE;
          end else begin
            idx_d     = idx_q + CNT_W'(1);
            out_val_d = next_val;
            sat_d     = sat_q | next_ovf;
            hcnt_d    = hold_q;
            state_d   = (hold_q == '0) ? EMIT : HOLD;
          end
        end
      end
      HOLD: begin
        hcnt_d  = hcnt_q - HOLD_W'(1);
        state_d = (hcnt_q == HOLD_W'(1)) ? EMIT : HOLD;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_valid = state_q == EMIT;
    busy      = (state_q == EMIT) || (state_q == HOLD);
    done      = state_q == DONE;
    out_val   = out_val_q;
    sat       = sat_q;
  end
endmodule

// File: doc/tanh_stim_sweep.md
# tanh_stim_sweep

Upstream stimulus stage for the tanh function model: generates a fixed-point input ramp in svreal fixed-point format (signed `WIDTH`, scale 2^`EXPONENT`) and presents one sample at a time over a valid/ready handshake to the block that drives the model's `in_` port. Each sweep is configured by start value, step, number of steps and optional hold gap between samples. Additions saturate, and a sticky flag reports any clipping.

## Interface
- `WIDTH`, 18, signed fixed-point width of the ramp (matches the model input `in_range`=10 at `EXPONENT`=-12)
- `EXPONENT`, -12, fixed-point exponent; informational only, no arithmetic depends on it
- `CNT_W`, 16, width of step count
- `HOLD_W`, 8, width of hold gap
- `clk` input 1: single clock, all state on rising edge
- `rst` input 1: synchronous, active-high reset
- `start` input 1: single-cycle sweep request
- `start_val` input `WIDTH` signed: first sample
- `step` input `WIDTH` signed: per-sample increment (may be negative or zero)
- `n_steps` input `CNT_W` unsigned: samples to emit
- `hold_cycles` input `HOLD_W` unsigned: idle cycles between accepted sample and next valid
- `out_val` output `WIDTH` signed: current sample
- `out_valid` output 1: sample available
- `out_ready` input 1: downstream accepts
- `busy` output 1: high in EMIT/HOLD
- `done` output 1: level, high after sweep completes until next start
- `sat` output 1: sticky, set if any ramp addition clipped

## Operation
- States: IDLE, EMIT, HOLD, DONE.
- IDLE/DONE + `start`: latch `step`, `n_steps`, `hold_cycles`, and clear `sat` and `done`. If `n_steps`==0, go to DONE. Otherwise set `out_val`=`start_val`, idx=0, and go to EMIT.
- EMIT: `out_valid`=1 and `out_val` stays stable until accepted.
- EMIT on accept (`out_valid`&&`out_ready`):
  - if idx==n_steps-1, go to DONE;
  - otherwise idx++, `out_val` becomes sat_add(`out_val`,`step`), and the next state is EMIT if hold==0, else HOLD with hcnt=hold.
- HOLD: `out_valid`=0 and hcnt decrements each cycle. At hcnt==1, go to EMIT.
- `start` is ignored in EMIT and HOLD. Config inputs are sampled only on an accepted `start`.
- Saturating add:
  - compute the sum in `WIDTH`+1 bits and clamp to [-2^(`WIDTH`-1), 2^(`WIDTH`-1)-1];
  - `sat` is set on the cycle a clamp occurs.
  - A clamped value is held on later steps if `step` keeps pushing the same way.
- The update is computed on the accept only, so `out_val` never changes while `out_valid`=1 and not accepted.
- `busy`=1 exactly in EMIT or HOLD. `done`=1 exactly in DONE.

## Timing
- Reset (any state, including mid-sweep): state IDLE, `out_val`=0, `out_valid`=0, `busy`=0, `done`=0, `sat`=0. The sweep in progress is abandoned, with no partial completion.
- All outputs are registered.
- `start` at edge t gives `out_valid`=1 (or `done`=1 for `n_steps`=0) from cycle t+1.
- Accept at edge k with hold=0: next sample valid at k+1 (back-to-back, 1 sample/cycle).
- Accept at edge k with hold=H>0: `out_valid`=0 for cycles k+1..k+H, next sample valid at k+H+1.
- Last accept at edge k: `out_valid`=0 and `done`=1 from k+1.
- `start` in the same cycle as the final accept is ignored, because the state is still EMIT.
- `rst` has priority over `start`.

## Structure
- Package `tanh_stim_pkg`:
  - state enum (IDLE, EMIT, HOLD, DONE);
  - default `WIDTH`/`EXPONENT` constants;
  - MAX/MIN fixed-point constants derived from `WIDTH`.
- Sub-module `fixed_sat_add`: combinational `WIDTH`-bit signed saturating adder, outputs sum and overflow flag. It is reusable for other svreal-side stimulus blocks.
- Top holds the FSM, idx counter, hold counter and config registers.

## Test plan
- start_val=-40960 (-10.0), step=4096, n_steps=21, hold=0, ready=1 -> 21 consecutive valid cycles -40960..40960 in steps of 4096, then `done`=1, `sat`=0.
- Same sweep with hold=3 and ready toggling pseudo-randomly -> the same 21 values in order. `out_val` is stable while stalled, and exactly 3 invalid cycles follow each accept.
- start_val=131000, step=100, n_steps=3 -> values 131000, 131071, 131071; `sat`=1 after second accept. Negative mirror case: start_val=-131000, step=-100 -> -131000, -131072, -131072.
- n_steps=0 + start -> no `out_valid`; `done`=1 at t+1.
- `rst` asserted mid-sweep (after 5 accepts) -> next cycle all outputs 0. A new start then sweeps from start_val with `sat` cleared.
- `start` pulsed during EMIT and on the final-accept cycle -> ignored, sweep unchanged. A start while in DONE -> `done`=0 and first sample at t+1.
